// File: rtl/coin_pkg.sv
// +-------------------------------------------------------------------+
// | coin_pkg : shared coin codes and scheduler state encoding         |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

package coin_pkg;

  localparam logic [1:0] COIN_NONE   = 2'b00;
  localparam logic [1:0] COIN_NICKEL = 2'b01;
  localparam logic [1:0] COIN_DIME   = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/coin_debounce.sv
// +-------------------------------------------------------------------+
// | coin_debounce : 2-flop sync, counter debounce, rising-edge event  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta    <= 1'b0;
      r_sync    <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_meta    <= i_raw;
      r_sync    <= r_meta;
      r_level_d <= r_level;
      // Any agreement restarts the count, so only an unbroken run flips the level.
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_level & ~r_level_d;

endmodule

`default_nettype wire

// File: rtl/coin_input_conditioner.sv
// +-------------------------------------------------------------------+
// | coin_input_conditioner : debounced coin sensors -> paced x1/x0    |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module coin_input_conditioner
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic nickel_raw,
  input  logic dime_raw,
  output logic x1,
  output logic x0,
  output logic coin_pending,
  output logic jam,
  output logic overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [AW:0]   C_FULL    = (AW + 1)'(FIFO_DEPTH);
  localparam logic [GW-1:0] C_GAP     = GW'(GAP_CYCLES);
  localparam logic [GW-1:0] C_GAP_ONE = GW'(1);

  logic w_nick_rise;
  logic w_dime_rise;
  logic w_nick_level;
  logic w_dime_level;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nickel (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (nickel_raw),
    .o_level (w_nick_level),
    .o_rise  (w_nick_rise)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dime (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (dime_raw),
    .o_level (w_dime_level),
    .o_rise  (w_dime_rise)
  );

  logic w_push;
  logic w_jam;
  assign w_push = w_nick_rise ^ w_dime_rise;
  assign w_jam  = w_nick_rise & w_dime_rise;

  logic          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_jam;
  logic          r_overflow;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_wr;
  logic          w_head;

  assign w_full  = (r_count == C_FULL);
  assign w_empty = (r_count == '0);
  // A pop in the same cycle frees the slot, so a push into a full queue survives.
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_head  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= w_dime_rise;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_jam      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_jam <= w_jam;
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [GW-1:0] r_gap;
  logic [GW-1:0] w_gap_nxt;
  logic [1:0]    r_code;
  logic [1:0]    w_code_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gap   <= '0;
      r_code  <= COIN_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= w_gap_nxt;
      r_code  <= w_code_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (!w_empty) w_state_nxt = ST_EMIT;
      ST_EMIT: w_state_nxt = ST_GAP;
      ST_GAP:  if (r_gap == C_GAP_ONE) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead and registered, so x1/x0 never glitch.
  always_comb begin
    w_pop      = 1'b0;
    w_code_nxt = COIN_NONE;
    w_gap_nxt  = r_gap;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_code_nxt = w_head ? COIN_DIME : COIN_NICKEL;
        end
      end
      ST_EMIT: w_gap_nxt = C_GAP;
      ST_GAP:  w_gap_nxt = r_gap - 1'b1;
      default: w_gap_nxt = '0;
    endcase
  end

  assign x1           = r_code[1];
  assign x0           = r_code[0];
  assign coin_pending = ~w_empty;
  assign jam          = r_jam;
  assign overflow     = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_coin_input_conditioner.sv
// +-------------------------------------------------------------------+
// | tb_coin_input_conditioner : scoreboard bench for the coin front end|
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module tb_coin_input_conditioner;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;
  // Long gap makes the drain slower than the fastest insertion rate, so the queue can fill.
  localparam int GAP   = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic nickel_raw = 1'b0;
  logic dime_raw = 1'b0;
  logic x1, x0, coin_pending, jam, overflow;

  coin_input_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .FIFO_DEPTH      (DEPTH),
    .GAP_CYCLES      (GAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .nickel_raw   (nickel_raw),
    .dime_raw     (dime_raw),
    .x1           (x1),
    .x0           (x0),
    .coin_pending (coin_pending),
    .jam          (jam),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];
  int cyc = 0;
  int pulse_cnt = 0;
  int last_pulse = -1000;
  int jam_cycles = 0;
  bit pend_seen = 1'b0;
  bit prev_x0 = 1'b0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      prev_x0    = 1'b0;
      last_pulse = -1000;
    end else begin
      if (coin_pending === 1'b1) pend_seen = 1'b1;
      if (jam === 1'b1) jam_cycles++;
      if (x0 === 1'b1) begin
        pulse_cnt++;
        check_value("pulse_width", 32'(prev_x0), 32'd0);
        check_value("pulse_spacing", 32'((cyc - last_pulse) >= GAP + 2), 32'd1);
        last_pulse = cyc;
        if (exp_q.size() == 0)
          check_value("unexpected_coin", 32'({x1, x0}), 32'(2'b00));
        else
          check_value("coin_code", 32'({x1, x0}), 32'(exp_q.pop_front()));
      end else if (x1 === 1'b1) begin
        check_value("code_10", 32'({x1, x0}), 32'(2'b00));
      end
      prev_x0 = (x0 === 1'b1);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic insert(input bit is_dime, input int hi, input int lo);
    if (is_dime) dime_raw = 1'b1; else nickel_raw = 1'b1;
    step(hi);
    dime_raw   = 1'b0;
    nickel_raw = 1'b0;
    step(lo);
  endtask

  task automatic wait_pulses(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && pulse_cnt < n; i++) step(1);
    check_value(tag, 32'(pulse_cnt), 32'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, pulses %0d", pulse_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int base;

    // Reset with toggling sensors
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      nickel_raw = i[0];
      dime_raw   = ~i[0];
      step(1);
      check_value("rst_x1", 32'(x1), 32'd0);
      check_value("rst_x0", 32'(x0), 32'd0);
      check_value("rst_jam", 32'(jam), 32'd0);
      check_value("rst_overflow", 32'(overflow), 32'd0);
      check_value("rst_pending", 32'(coin_pending), 32'd0);
    end
    nickel_raw = 1'b0;
    dime_raw   = 1'b0;
    rst = 1'b0;
    step(12);
    check_value("idle_pulses", 32'(pulse_cnt), 32'd0);
    check_value("idle_pending", 32'(coin_pending), 32'd0);

    // Single nickel, latency and no event on release
    exp_q.push_back(2'b01);
    t0 = cyc;
    insert(1'b0, 10, GAP + 20);
    check_value("nickel_pulses", 32'(pulse_cnt), 32'd1);
    check_value("nickel_latency", 32'(last_pulse - t0), 32'(DEB + 4));
    check_value("nickel_sb_empty", 32'(exp_q.size()), 32'd0);

    // Dime, nickel, dime back to back
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b11);
    insert(1'b1, 6, 6);
    insert(1'b0, 6, 6);
    insert(1'b1, 6, 6);
    wait_pulses("seq_pulses", 4, 3 * (GAP + 2) + 40);
    step(GAP + 5);
    check_value("seq_sb_empty", 32'(exp_q.size()), 32'd0);

    // Short glitch is filtered
    base = pulse_cnt;
    pend_seen = 1'b0;
    insert(1'b0, 2, 30);
    check_value("glitch_pulses", 32'(pulse_cnt), 32'(base));
    check_value("glitch_pending", 32'(pend_seen), 32'd0);

    // Simultaneous insertion jams
    jam_cycles = 0;
    nickel_raw = 1'b1;
    dime_raw   = 1'b1;
    step(8);
    nickel_raw = 1'b0;
    dime_raw   = 1'b0;
    step(20);
    check_value("jam_cycles", 32'(jam_cycles), 32'd1);
    check_value("jam_pulses", 32'(pulse_cnt), 32'(base));
    check_value("jam_pending", 32'(pend_seen), 32'd0);

    // Flood: first coin drains at once, next four fill the queue, sixth is dropped
    base = pulse_cnt;
    for (int i = 0; i < 5; i++) exp_q.push_back(2'b01);
    for (int i = 0; i < 6; i++) insert(1'b0, 5, 5);
    check_value("flood_overflow", 32'(overflow), 32'd1);
    check_value("flood_pending", 32'(coin_pending), 32'd1);
    wait_pulses("flood_drain", base + 2, GAP + 20);
    step(3);
    check_value("flood_pending2", 32'(coin_pending), 32'd1);
    check_value("flood_queued", 32'(exp_q.size()), 32'd3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    exp_q.delete();
    check_value("post_rst_overflow", 32'(overflow), 32'd0);
    check_value("post_rst_pending", 32'(coin_pending), 32'd0);
    check_value("post_rst_x0", 32'(x0), 32'd0);
    step(GAP + 20);
    check_value("post_rst_pulses", 32'(pulse_cnt), 32'(base + 2));
    check_value("post_rst_pending2", 32'(coin_pending), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
